// File: rtl/writeback_cycle_if.sv
// rtl/writeback_cycle_if.sv - MEM->WB bundle carrying one instruction into the write-back stage
interface writeback_cycle_if #(
   parameter int XLEN = 32
);
   logic [XLEN-1:0] wb_pc_add4;
   logic [XLEN-1:0] wb_alu_data;
   logic [XLEN-1:0] wb_ld_data;
   logic [31:0]     wb_inst;
   logic [XLEN-1:0] wb_pc_debug;
   logic [1:0]      wb_sel;
   logic            wb_rd_wren;
   logic            wb_insn_vld;
   logic            wb_ctrl;

   modport master (
      output wb_pc_add4, wb_alu_data, wb_ld_data, wb_inst, wb_pc_debug,
      output wb_sel, wb_rd_wren, wb_insn_vld, wb_ctrl
   );

   modport slave (
      input wb_pc_add4, wb_alu_data, wb_ld_data, wb_inst, wb_pc_debug,
      input wb_sel, wb_rd_wren, wb_insn_vld, wb_ctrl
   );
endinterface

// File: rtl/writeback_cycle.sv
// rtl/writeback_cycle.sv - write-back stage: regfile write mux, WB hold entry, counters, commit trace
module writeback_cycle #(
   parameter int XLEN  = 32,
   parameter int CNT_W = 64
) (
   input  logic             i_clk,
   input  logic             i_reset,
   writeback_cycle_if.slave wb,
   input  logic             i_cnt_clr,
   output logic [4:0]       o_rf_rd_addr,
   output logic [XLEN-1:0]  o_rf_rd_data,
   output logic             o_rf_rd_wren,
   output logic [4:0]       o_hold_rd_addr,
   output logic [XLEN-1:0]  o_hold_rd_data,
   output logic             o_hold_vld,
   output logic [CNT_W-1:0] o_mcycle,
   output logic [CNT_W-1:0] o_minstret,
   output logic [CNT_W-1:0] o_mctrl,
   output logic             o_commit_vld,
   output logic [XLEN-1:0]  o_commit_pc,
   output logic [31:0]      o_commit_inst
);

   logic [4:0]      rd;
   logic            rd_zero;
   logic [XLEN-1:0] wb_mux;

   always_comb begin
      rd      = wb.wb_inst[11:7];
      rd_zero = (rd == 5'd0);
      wb_mux  = '0;
      case (wb.wb_sel)
         2'b00:   wb_mux = wb.wb_pc_add4;
         2'b10:   wb_mux = wb.wb_ld_data;
         default: wb_mux = wb.wb_alu_data;
      endcase
   end

   // x0 writes are suppressed and read as zero so the bypass never forwards garbage for rd=0
   assign o_rf_rd_addr = rd;
   assign o_rf_rd_data = rd_zero ? '0 : wb_mux;
   assign o_rf_rd_wren = wb.wb_rd_wren & wb.wb_insn_vld & ~rd_zero;

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         o_hold_rd_addr <= '0;
         o_hold_rd_data <= '0;
         o_hold_vld     <= 1'b0;
      end else begin
         o_hold_rd_addr <= o_rf_rd_addr;
         o_hold_rd_data <= o_rf_rd_data;
         o_hold_vld     <= o_rf_rd_wren;
      end
   end

   // Clear wins over increment so software sees an exact zero after clearing
   always_ff @(posedge i_clk) begin
      if (i_reset || i_cnt_clr) begin
         o_mcycle   <= '0;
         o_minstret <= '0;
         o_mctrl    <= '0;
      end else begin
         o_mcycle <= o_mcycle + CNT_W'(1);
         if (wb.wb_insn_vld) begin
            o_minstret <= o_minstret + CNT_W'(1);
         end
         if (wb.wb_insn_vld && wb.wb_ctrl) begin
            o_mctrl <= o_mctrl + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         o_commit_vld  <= 1'b0;
         o_commit_pc   <= '0;
         o_commit_inst <= '0;
      end else begin
         o_commit_vld <= wb.wb_insn_vld;
         if (wb.wb_insn_vld) begin
            o_commit_pc   <= wb.wb_pc_debug;
            o_commit_inst <= wb.wb_inst;
         end
      end
   end

endmodule

// File: tb/tb_writeback_cycle.sv
// tb/tb_writeback_cycle.sv - directed scoreboard bench for writeback_cycle
module tb_writeback_cycle;

   logic        i_clk = 1'b0;
   logic        i_reset;
   logic        i_cnt_clr;

   logic [4:0]  rf_addr, hold_addr, s_rf_addr, s_hold_addr;
   logic [31:0] rf_data, hold_data, commit_pc, s_rf_data, s_hold_data, s_commit_pc;
   logic        rf_wren, hold_vld, commit_vld, s_rf_wren, s_hold_vld, s_commit_vld;
   logic [31:0] commit_inst, s_commit_inst;
   logic [63:0] mcycle, minstret, mctrl;
   logic [7:0]  s_mcycle, s_minstret, s_mctrl;

   writeback_cycle_if #(.XLEN(32)) wb_bus ();

   always #5 i_clk = ~i_clk;

   writeback_cycle #(.XLEN(32), .CNT_W(64)) dut (
      .i_clk(i_clk), .i_reset(i_reset), .wb(wb_bus.slave), .i_cnt_clr(i_cnt_clr),
      .o_rf_rd_addr(rf_addr), .o_rf_rd_data(rf_data), .o_rf_rd_wren(rf_wren),
      .o_hold_rd_addr(hold_addr), .o_hold_rd_data(hold_data), .o_hold_vld(hold_vld),
      .o_mcycle(mcycle), .o_minstret(minstret), .o_mctrl(mctrl),
      .o_commit_vld(commit_vld), .o_commit_pc(commit_pc), .o_commit_inst(commit_inst)
   );

   writeback_cycle #(.XLEN(32), .CNT_W(8)) dut8 (
      .i_clk(i_clk), .i_reset(i_reset), .wb(wb_bus.slave), .i_cnt_clr(i_cnt_clr),
      .o_rf_rd_addr(s_rf_addr), .o_rf_rd_data(s_rf_data), .o_rf_rd_wren(s_rf_wren),
      .o_hold_rd_addr(s_hold_addr), .o_hold_rd_data(s_hold_data), .o_hold_vld(s_hold_vld),
      .o_mcycle(s_mcycle), .o_minstret(s_minstret), .o_mctrl(s_mctrl),
      .o_commit_vld(s_commit_vld), .o_commit_pc(s_commit_pc), .o_commit_inst(s_commit_inst)
   );

   typedef struct {
      logic [4:0]  hold_addr;
      logic [31:0] hold_data;
      logic        hold_vld;
      logic        commit_vld;
      logic [31:0] commit_pc;
      logic [31:0] commit_inst;
   } exp_t;

   exp_t        exp_q[$];
   int          n_assert = 0;
   int          n_fail   = 0;
   logic [63:0] m_cyc, m_inst, m_ctrl;
   logic [31:0] m_pc, m_ins;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      n_assert++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic step(input logic rst, input logic clr, input logic [1:0] sel,
                       input logic [31:0] pc4, input logic [31:0] alu, input logic [31:0] ld,
                       input logic [4:0] rd, input logic wren, input logic vld, input logic ctrl);
      exp_t        e;
      logic [31:0] inst, pcd, d;
      inst       = $urandom;
      inst[11:7] = rd;
      pcd        = $urandom & 32'hFFFF_FFFC;
      i_reset = rst;
      i_cnt_clr = clr;
      wb_bus.wb_sel = sel;
      wb_bus.wb_pc_add4 = pc4;
      wb_bus.wb_alu_data = alu;
      wb_bus.wb_ld_data = ld;
      wb_bus.wb_inst = inst;
      wb_bus.wb_pc_debug = pcd;
      wb_bus.wb_rd_wren = wren;
      wb_bus.wb_insn_vld = vld;
      wb_bus.wb_ctrl = ctrl;
      #1;
      d = (sel == 2'b10) ? ld : (sel == 2'b00) ? pc4 : alu;
      if (rd == 5'd0) d = 32'd0;
      if (!rst) begin
         chk("rf_addr", {59'd0, rf_addr}, {59'd0, rd});
         chk("rf_data", {32'd0, rf_data}, {32'd0, d});
         chk("rf_wren", {63'd0, rf_wren}, {63'd0, wren & vld & (rd != 5'd0)});
      end else if (!vld) begin
         chk("rf_wren_rst", {63'd0, rf_wren}, 64'd0);
      end
      e.hold_addr = rst ? 5'd0 : rd;
      e.hold_data = rst ? 32'd0 : d;
      e.hold_vld  = rst ? 1'b0 : (wren & vld & (rd != 5'd0));
      e.commit_vld = rst ? 1'b0 : vld;
      if (rst) begin
         m_pc = 0; m_ins = 0;
      end else if (vld) begin
         m_pc = pcd; m_ins = inst;
      end
      e.commit_pc = m_pc;
      e.commit_inst = m_ins;
      if (rst || clr) begin
         m_cyc = 0; m_inst = 0; m_ctrl = 0;
      end else begin
         m_cyc++;
         if (vld) m_inst++;
         if (vld && ctrl) m_ctrl++;
      end
      exp_q.push_back(e);
      @(posedge i_clk);
      #1;
      e = exp_q.pop_front();
      chk("hold_addr", {59'd0, hold_addr}, {59'd0, e.hold_addr});
      chk("hold_data", {32'd0, hold_data}, {32'd0, e.hold_data});
      chk("hold_vld", {63'd0, hold_vld}, {63'd0, e.hold_vld});
      chk("commit_vld", {63'd0, commit_vld}, {63'd0, e.commit_vld});
      chk("commit_pc", {32'd0, commit_pc}, {32'd0, e.commit_pc});
      chk("commit_inst", {32'd0, commit_inst}, {32'd0, e.commit_inst});
      chk("mcycle", mcycle, m_cyc);
      chk("minstret", minstret, m_inst);
      chk("mctrl", mctrl, m_ctrl);
      chk("mcycle8", {56'd0, s_mcycle}, {56'd0, m_cyc[7:0]});
   endtask

   initial begin
      // reset: all registered state to zero
      step(1, 0, 2'b01, 32'h4, 32'h5, 32'h6, 5'd3, 1, 0, 0);
      step(1, 0, 2'b01, 32'h4, 32'h5, 32'h6, 5'd3, 1, 0, 0);
      // T4: 10 valid (3 control transfers) and 2 bubbles
      for (int i = 0; i < 12; i++) begin
         step(0, 0, 2'($urandom_range(0, 3)), $urandom, $urandom, $urandom,
              5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
              (i != 4 && i != 9), (i == 1 || i == 6 || i == 11));
      end
      chk("t4_mcycle", mcycle, 64'd12);
      chk("t4_minstret", minstret, 64'd10);
      chk("t4_mctrl", mctrl, 64'd3);
      // T1, T2, T3
      step(0, 0, 2'b01, 32'h0, 32'h1234, 32'h0, 5'd5, 1, 1, 0);
      chk("t1_hold_data", {32'd0, hold_data}, 64'h1234);
      step(0, 0, 2'b10, 32'h0, 32'h0, 32'hDEADBEEF, 5'd0, 1, 1, 0);
      chk("t2_hold_vld", {63'd0, hold_vld}, 64'd0);
      step(0, 0, 2'b00, 32'h104, 32'h0, 32'h0, 5'd7, 1, 0, 0);
      step(0, 0, 2'b00, 32'h108, 32'h1, 32'h2, 5'd8, 1, 1, 0);
      step(0, 0, 2'b11, 32'h10C, 32'h99, 32'h2, 5'd9, 1, 1, 1);
      // T5: clear beats a valid control-transfer increment, then counting resumes
      step(0, 1, 2'b01, 32'h0, 32'h7, 32'h0, 5'd1, 1, 1, 1);
      chk("t5_mcycle_clr", mcycle, 64'd0);
      step(0, 0, 2'b01, 32'h0, 32'h8, 32'h0, 5'd2, 1, 1, 1);
      chk("t5_mctrl_resume", mctrl, 64'd1);
      // T6: run the 8-bit counters past their wrap point
      for (int i = 0; i < 270; i++) begin
         step(0, 0, 2'($urandom_range(0, 3)), $urandom, $urandom, $urandom,
              5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end
      // reset mid-stream with a valid writing instruction present
      step(1, 1, 2'b01, 32'h0, 32'hABCD, 32'h0, 5'd4, 1, 1, 1);
      chk("rst_mcycle8", {56'd0, s_mcycle}, 64'd0);
      step(0, 0, 2'b01, 32'h0, 32'h55, 32'h0, 5'd6, 1, 1, 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
